alsu_driver: RTL

ALSU_DRIVER -- requirements
Module: alsu_driver

---
 rtl/alsu_pkg.sv | 44 ++++
 rtl/alsu_drv_stats.sv | 45 ++++
 rtl/alsu_driver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alsu_pkg.sv
// alsu_pkg: shared types and width constants for the ALSU command driver.
// Optional statistics counters are enabled with the ALSU_DRV_STATS_EN macro.
package alsu_pkg;

  localparam int ALSU_OPND_W = 3;   // A / B operand width
  localparam int ALSU_RES_W  = 6;   // ALSU result width
  localparam int ALSU_LED_W  = 16;  // ALSU invalid-indicator width
  localparam int ALSU_CTRL_W = 7;   // packed control bits
  localparam int ALSU_CMD_W  = 16;  // full command word
  localparam int STAT_W      = 16;  // statistics counter width

  typedef enum logic [2:0] {
    OP_OR     = 3'd0,
    OP_XOR    = 3'd1,
    OP_ADD    = 3'd2,
    OP_MULT   = 3'd3,
    OP_SHIFT  = 3'd4,
    OP_ROTATE = 3'd5,
    OP_INV6   = 3'd6,
    OP_INV7   = 3'd7
  } opcode_e;

  // Field order matches the cmd_data bit layout, MSB first.
  typedef struct packed {
    opcode_e                opcode;
    logic [ALSU_OPND_W-1:0] a;
    logic [ALSU_OPND_W-1:0] b;
    logic                   cin;
    logic                   serial_in;
    logic                   direction;
    logic                   red_op_a;
    logic                   red_op_b;
    logic                   bypass_a;
    logic                   bypass_b;
  } alsu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } drv_state_e;

endpackage

// File: rtl/alsu_drv_stats.sv
// alsu_drv_stats: saturating response / invalid-response counters.
// Instantiated by alsu_driver only when ALSU_DRV_STATS_EN is defined.
module alsu_drv_stats
  import alsu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              resp_hs,
  input  logic              resp_invalid,
  output logic [STAT_W-1:0] op_count,
  output logic [STAT_W-1:0] invalid_count
);

  logic [STAT_W-1:0] op_count_q, op_count_d;
  logic [STAT_W-1:0] invalid_count_q, invalid_count_d;

  // Next-count logic: bump on handshake, stick at all-ones.
  always_comb begin
    op_count_d      = op_count_q;
    invalid_count_d = invalid_count_q;
    if (resp_hs) begin
      if (op_count_q != '1) begin
        op_count_d = op_count_q + 1'b1;
      end
      if (resp_invalid && (invalid_count_q != '1)) begin
        invalid_count_d = invalid_count_q + 1'b1;
      end
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count_q      <= '0;
      invalid_count_q <= '0;
    end else begin
      op_count_q      <= op_count_d;
      invalid_count_q <= invalid_count_d;
    end
  end

  assign op_count      = op_count_q;
  assign invalid_count = invalid_count_q;

endmodule

// File: rtl/alsu_driver.sv
// alsu_driver: ready/valid command front-end for a fixed-latency ALSU.
// Issues one command at a time, waits LATENCY cycles, captures the result.
// Define ALSU_DRV_STATS_EN to enable the op_count / invalid_count counters.
module alsu_driver
  import alsu_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ALSU_CMD_W-1:0]  cmd_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ALSU_RES_W-1:0]  resp_out,
  output logic                   resp_invalid,
  output logic [ALSU_OPND_W-1:0] alsu_A,
  output logic [ALSU_OPND_W-1:0] alsu_B,
  output logic [2:0]             alsu_opcode,
  output logic [ALSU_CTRL_W-1:0] alsu_ctrl,
  input  logic [ALSU_RES_W-1:0]  alsu_out,
  input  logic [ALSU_LED_W-1:0]  alsu_leds,
  output logic [STAT_W-1:0]      op_count,
  output logic [STAT_W-1:0]      invalid_count
);

  // The wait counter holds LATENCY-1 down to 0.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("alsu_driver: LATENCY must be at least 1");
    end
  endgenerate

  drv_state_e             state_q, state_d;
  alsu_cmd_t              cmd_q, cmd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ALSU_RES_W-1:0]  resp_out_q, resp_out_d;
  logic                   resp_invalid_q, resp_invalid_d;

  // Next-state, capture and output decode for the issue/wait/respond FSM.
  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    cnt_d          = cnt_q;
    resp_out_d     = resp_out_q;
    resp_invalid_d = resp_invalid_q;
    cmd_ready      = 1'b0;
    resp_valid     = 1'b0;
    alsu_A         = '0;
    alsu_B         = '0;
    alsu_opcode    = '0;
    alsu_ctrl      = '0;

    case (state_q)
      ST_IDLE: begin
        // Not ready during the reset cycle itself.
        cmd_ready = !reset;
        if (cmd_valid) begin
          cmd_d   = alsu_cmd_t'(cmd_data);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Operands are presented for exactly this one cycle; the ALSU's
        // idle input (all zero) is a harmless OR of 0 and 0.
        alsu_A      = cmd_q.a;
        alsu_B      = cmd_q.b;
        alsu_opcode = cmd_q.opcode;
        alsu_ctrl   = {cmd_q.cin, cmd_q.serial_in, cmd_q.direction,
                       cmd_q.red_op_a, cmd_q.red_op_b,
                       cmd_q.bypass_a, cmd_q.bypass_b};
        cnt_d       = CNT_W'(LATENCY - 1);
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          resp_out_d     = alsu_out;
          resp_invalid_d = (alsu_leds != '0);
          state_d        = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched command, wait counter and captured response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cmd_q          <= '0;
      cnt_q          <= '0;
      resp_out_q     <= '0;
      resp_invalid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      cnt_q          <= cnt_d;
      resp_out_q     <= resp_out_d;
      resp_invalid_q <= resp_invalid_d;
    end
  end

  assign resp_out     = resp_out_q;
  assign resp_invalid = resp_invalid_q;

`ifdef ALSU_DRV_STATS_EN
  alsu_drv_stats u_stats (
    .clk           (clk),
    .reset         (reset),
    .resp_hs       (resp_valid & resp_ready),
    .resp_invalid  (resp_invalid_q),
    .op_count      (op_count),
    .invalid_count (invalid_count)
  );
`else
  assign op_count      = '0;
  assign invalid_count = '0;
`endif

endmodule
